// File: rtl/m1t_mem_pkg.sv
// Shared types and default widths for the M1T unified-memory arbiter.
// Latency: n/a (types, constants and a pure helper function only).
// Backpressure: n/a.
package m1t_mem_pkg;

    localparam int M1T_ADDR_W = 15;
    localparam int M1T_DATA_W = 16;
    localparam int M1T_TAG_W  = 4;

    // One in-flight read: who gets the data back and, for data reads, where it goes.
    typedef struct packed {
        logic                 valid;
        logic                 is_fetch;
        logic [M1T_TAG_W-1:0] tag;
    } resp_entry_t;

    // A flush kills fetch responses only; data reads always complete.
    function automatic resp_entry_t apply_flush(input resp_entry_t e, input logic flush);
        resp_entry_t r;
        r = e;
        if (flush && e.is_fetch) begin
            r.valid = 1'b0;
        end
        return r;
    endfunction

endpackage

// File: rtl/mem_resp_pipe_m1t.sv
// Response tracker: carries {valid, is_fetch, tag} alongside the RAM read latency.
// Latency: RAM_LAT cycles from push to head; head is flush-masked combinationally.
// Backpressure: none, advances every cycle; the consumer must take head when valid.
// Ports: clk, async_rst, flush (kill in-flight fetches), push (new entry), head (exiting entry).
module mem_resp_pipe_m1t
    import m1t_mem_pkg::*;
#(
    parameter int RAM_LAT = 1
)(
    input  logic        clk,
    input  logic        async_rst,
    input  logic        flush,
    input  resp_entry_t push,
    output resp_entry_t head
);

    resp_entry_t stage [RAM_LAT];

    // The entry pushed this cycle is never flushed; only entries already in flight are.
    always_ff @(posedge clk or posedge async_rst) begin
        if (async_rst) begin
            for (int i = 0; i < RAM_LAT; i++) begin
                stage[i] <= '0;
            end
        end else begin
            stage[0] <= push;
            for (int i = 1; i < RAM_LAT; i++) begin
                stage[i] <= apply_flush(stage[i-1], flush);
            end
        end
    end

    // The exiting entry is also in flight, so a flush in its return cycle suppresses it.
    assign head = apply_flush(stage[RAM_LAT-1], flush);

endmodule

// File: rtl/unified_mem_arbiter_m1t.sv
// Arbitrates one single-port RAM between instruction fetch and data port, one access per cycle.
// Latency: grant is combinational; read responses return exactly RAM_LAT cycles after grant.
// Backpressure: losing side sees if_stall / no d_gnt and must hold its request; no buffering.
// Ports: fetch side (if_*), data side (d_*), RAM macro side (ram_*), clk and async_rst.
// TAG_W must equal the package tag width, since the response entry struct is sized from it.
module unified_mem_arbiter_m1t
    import m1t_mem_pkg::*;
#(
    parameter int ADDR_W    = M1T_ADDR_W,
    parameter int DATA_W    = M1T_DATA_W,
    parameter int TAG_W     = M1T_TAG_W,
    parameter int RAM_LAT   = 1,
    parameter int MAX_D_RUN = 4
)(
    input  logic              clk,
    input  logic              async_rst,
    input  logic              if_req,
    input  logic [ADDR_W-1:0] if_addr,
    input  logic              if_flush,
    output logic              if_stall,
    output logic              if_rvalid,
    output logic [DATA_W-1:0] if_rdata,
    input  logic              d_req,
    input  logic              d_we,
    input  logic [ADDR_W-1:0] d_addr,
    input  logic [1:0]        d_be,
    input  logic [DATA_W-1:0] d_wdata,
    input  logic [TAG_W-1:0]  d_tag,
    output logic              d_gnt,
    output logic              d_rvalid,
    output logic [DATA_W-1:0] d_rdata,
    output logic [TAG_W-1:0]  d_rtag,
    output logic              ram_en,
    output logic              ram_we,
    output logic [ADDR_W-1:0] ram_addr,
    output logic [1:0]        ram_be,
    output logic [DATA_W-1:0] ram_wdata,
    input  logic [DATA_W-1:0] ram_rdata
);

    localparam logic [3:0] MAX_RUN = 4'(MAX_D_RUN);

    logic              data_gnt;
    logic              fetch_gnt;
    logic [3:0]        run_cnt;
    resp_entry_t       push;
    resp_entry_t       head;
    logic [DATA_W-1:0] if_rdata_q;
    logic [DATA_W-1:0] d_rdata_q;
    logic [TAG_W-1:0]  d_rtag_q;

    // Data wins unless it has already taken MAX_D_RUN grants in a row while fetch waited.
    // Reset gates both grants so the RAM is never enabled while reset is asserted.
    assign data_gnt  = !async_rst && d_req && (!if_req || (run_cnt < MAX_RUN));
    assign fetch_gnt = !async_rst && if_req && !data_gnt;

    assign d_gnt    = data_gnt;
    assign if_stall = !async_rst && if_req && !fetch_gnt;

    assign ram_en    = data_gnt || fetch_gnt;
    assign ram_we    = data_gnt && d_we;
    assign ram_addr  = data_gnt ? d_addr : (fetch_gnt ? if_addr : '0);
    assign ram_be    = (data_gnt && d_we) ? d_be : (ram_en ? 2'b11 : 2'b00);
    assign ram_wdata = (data_gnt && d_we) ? d_wdata : '0;

    always_ff @(posedge clk or posedge async_rst) begin
        if (async_rst) begin
            run_cnt <= '0;
        end else if (!if_req || fetch_gnt) begin
            run_cnt <= '0;
        end else if (data_gnt && (run_cnt < MAX_RUN)) begin
            run_cnt <= run_cnt + 4'd1;
        end
    end

    // Only reads occupy a response slot; writes leave a bubble.
    always_comb begin
        push          = '0;
        push.valid    = fetch_gnt || (data_gnt && !d_we);
        push.is_fetch = fetch_gnt;
        push.tag      = data_gnt ? d_tag : '0;
    end

    mem_resp_pipe_m1t #(
        .RAM_LAT (RAM_LAT)
    ) u_resp_pipe (
        .clk       (clk),
        .async_rst (async_rst),
        .flush     (if_flush),
        .push      (push),
        .head      (head)
    );

    assign if_rvalid = head.valid && head.is_fetch;
    assign d_rvalid  = head.valid && !head.is_fetch;

    // RAM data is only guaranteed during the return cycle, so the last value is held here.
    always_ff @(posedge clk or posedge async_rst) begin
        if (async_rst) begin
            if_rdata_q <= '0;
            d_rdata_q  <= '0;
            d_rtag_q   <= '0;
        end else begin
            if (if_rvalid) begin
                if_rdata_q <= ram_rdata;
            end
            if (d_rvalid) begin
                d_rdata_q <= ram_rdata;
                d_rtag_q  <= head.tag;
            end
        end
    end

    assign if_rdata = if_rvalid ? ram_rdata : if_rdata_q;
    assign d_rdata  = d_rvalid  ? ram_rdata : d_rdata_q;
    assign d_rtag   = d_rvalid  ? head.tag  : d_rtag_q;

endmodule

// File: doc/unified_mem_arbiter_m1t.md
Name: unified_mem_arbiter_m1t

Overview:
- Shares one single-port synchronous RAM between the core's instruction-fetch port and its data port, so the M1T SOC can execute from a writable unified memory instead of a read-only instruction ROM.
- Sits between Core_m1 (fetch side and data side) and the RAM macro.
- Per cycle it arbitrates one access, drives the RAM and routes the read response back to the winner after a fixed latency.
- Provides the stall signal that feeds the core's icache_miss input.

Parameters:
- ADDR_W, 15, word address width.
- DATA_W, 16, data width.
- TAG_W, 4, data-read writeback tag width.
- RAM_LAT, 1, RAM read latency in cycles (1 or 2).
- MAX_D_RUN, 4, max consecutive data grants while fetch waits (range 1-15).

Ports:
- clk  in  1  system clock
- async_rst  in  1  asynchronous, active-high reset
- if_req  in  1  fetch request
- if_addr  in  ADDR_W  fetch word address
- if_flush  in  1  discard any fetch response still in flight
- if_stall  out  1  fetch not granted this cycle (to core icache_miss)
- if_rvalid  out  1  fetch data valid
- if_rdata  out  DATA_W  fetched instruction
- d_req  in  1  data request
- d_we  in  1  1 = write, 0 = read
- d_addr  in  ADDR_W  data word address
- d_be  in  2  byte enables for writes
- d_wdata  in  DATA_W  write data
- d_tag  in  TAG_W  read writeback destination
- d_gnt  out  1  data request accepted this cycle
- d_rvalid  out  1  data read response valid
- d_rdata  out  DATA_W  read data
- d_rtag  out  TAG_W  tag of the returned read
- ram_en  out  1  RAM access enable
- ram_we  out  1  RAM write enable
- ram_addr  out  ADDR_W  RAM address
- ram_be  out  2  RAM byte enables
- ram_wdata  out  DATA_W  RAM write data
- ram_rdata  in  DATA_W  RAM read data, valid RAM_LAT cycles after ram_en with ram_we=0

Behaviour:
- Reset (async assert, release synchronous to clk): all outputs 0, starvation counter 0, response pipeline cleared. ram_en must not assert during reset.
- Grant decision is combinational from the current request inputs and registered state.
  - Data has priority: if d_req=1 and (if_req=0 or run_cnt<MAX_D_RUN), grant data.
  - Otherwise, if if_req=1, grant fetch.
- Outputs for the granted side:
  - d_gnt=1 when data is granted.
  - if_stall = if_req && !fetch_granted.
  - The RAM outputs are a direct mux of the winner. ram_en=0 when there is no request. ram_be is forced to 2'b11 on fetch and data reads.
- Starvation counter run_cnt:
  - Increments on a data grant while if_req=1, saturating at MAX_D_RUN.
  - Resets to 0 on a fetch grant or when if_req=0.
  - Consequence: with both requesting continuously, the grant pattern is MAX_D_RUN data grants, then 1 fetch grant, repeating.
- Response pipeline: a RAM_LAT-deep shift register carries {valid, is_fetch, tag} for each read grant. Writes carry nothing.
- At pipeline exit:
  - Fetch entries: if_rvalid=1, if_rdata=ram_rdata.
  - Data entries: d_rvalid=1, d_rdata=ram_rdata, d_rtag=tag.
  - The response valids are single-cycle pulses. rdata holds its last value otherwise.
- Ordering: responses return in grant order, exactly RAM_LAT cycles after the grant. At most one response per cycle.
- if_flush=1 clears the is_fetch valid bit of every in-flight entry, so no if_rvalid arises from them. A fetch granted in the same cycle as if_flush is not killed.
- The requester must hold a stalled request stable. The arbiter keeps no request buffer.
- Same-cycle write then read of the same address by different ports is impossible (one grant per cycle). Read-after-write ordering follows the RAM macro's write-first semantics.

Decomposition:
- Shared package m1t_mem_pkg holds:
  - a resp_entry_t struct {valid, is_fetch, tag};
  - the constant defaults for ADDR_W, DATA_W and TAG_W.
- One natural sub-module: mem_resp_pipe_m1t, the RAM_LAT-stage response shift register with flush.
- The arbiter and starvation counter stay in the top module.

Test Plan:
- Fetch only: if_req=1, addresses 0x0000 to 0x0003, RAM preloaded with 0x1000+addr, RAM_LAT=1 -> if_stall=0 throughout; if_rvalid one cycle later with 0x1000..0x1003 in order.
- Contention, MAX_D_RUN=4: if_req and d_req (reads) held high for 15 cycles -> grant pattern D,D,D,D,I repeated 3 times; if_stall high on exactly the 12 data cycles; d_rtag values return in issue order.
- Write then read: data write 0xBEEF with be=2'b01 to 0x0010 (initial 0x1234), then a data read with tag 0x7 -> d_rdata=0x12EF, d_rtag=0x7, ram_be=2'b01 on the write cycle.
- Flush, RAM_LAT=2: fetch granted at cycle N, if_flush at N+1 -> no if_rvalid at N+2; a fetch granted at N+1 still returns at N+3.
- Reset mid-operation: assert async_rst between clock edges while 2 reads are in flight -> all outputs 0 immediately; after release, no stale if_rvalid or d_rvalid; run_cnt restarts from 0.
- Idle: no requests for 10 cycles -> ram_en=0, d_gnt=0, if_stall=0 throughout.
